mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequencer/arbiter that shares the SISC's single-ported memory between the instruction-fetch path (IR load) and the data path (LOD/STR). Accepts requests from both ports, grants one at a time with round-robin on ties, drives the memory for a fixed read latency, and returns read data with a one-cycle acknowledge. Sits between `ctrl`/datapath and the memory model.

## Interface
- AW, 16: address width.
- DW, 32: data width.
- MEM_LAT, 1: memory read latency in cycles. Legal range 1..7; anything else is an elaboration error.

- clk  in  1  system clock; all state changes on its rising edge.
- rst_f  in  1  reset; synchronous, active-low.
- hold  in  1  when 1, no new grant is issued; an in-flight access completes normally.
- if_req  in  1  fetch read request; held high until if_ack.
- if_addr  in  AW  fetch address.
- if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid.
- if_rdata  out  DW  fetched word; held until next if_ack.
- dm_req  in  1  data request; held high until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  store data.
- dm_ack  out  1  one-cycle pulse: data access complete.
- dm_rdata  out  DW  loaded word; updated only on a load ack, held otherwise.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable; valid only with mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid MEM_LAT cycles after mem_en.
- busy  out  1  1 whenever state is not IDLE.
- last_grant  out  1  port granted most recently: 0 = fetch, 1 = data.

## Operation
- States: IDLE, WAIT, ACK.
- Reset (rst_f low at a rising edge): state IDLE; every output 0 (if_ack, dm_ack, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, busy, last_grant); latency counter 0. Overrides all other inputs.
- IDLE: if hold = 1 or no request, stay. Otherwise grant:
  - only one req high: that port.
  - both high: port opposite last_grant. After reset last_grant = 0, so data wins the first tie.
  - On grant: latch port id, addr, we (fetch forces we = 0), wdata; update last_grant; go to WAIT; load counter with MEM_LAT-1 for reads, 0 for writes.
- WAIT: mem_en = 1 and mem_we = latched we in the first WAIT cycle only. mem_addr and mem_wdata hold the latched values for all of WAIT. Counter decrements each cycle; when it is 0, go to ACK. For reads, mem_rdata is captured into the granted port's rdata register on that transition edge.
- ACK: the granted port's ack = 1 for exactly one cycle. busy stays 1. Next state is IDLE.
- Requester rules:
  - req must be low in the cycle after its ack; if it is still high, it is treated as a new request.
  - Changes to addr/we/wdata after the grant are ignored.
  - Requests raised during WAIT or ACK are not lost while held high; they are evaluated in the next IDLE.
- Writes never update either rdata register.
- hold does not affect an access already in WAIT or ACK.

## Timing
- Read: req sampled high in IDLE (cycle 0) -> mem_en in cycle 1 -> ack in cycle 1+MEM_LAT. Total latency is MEM_LAT+1 cycles.
- Write: mem_en with mem_we in cycle 1 -> ack in cycle 2, independent of MEM_LAT.
- Minimum spacing between grants: one IDLE cycle after each ACK. Back-to-back reads (MEM_LAT = 1) issue one grant every 3 cycles.
- Reset during WAIT or ACK: no ack is issued for the abandoned access. All outputs are 0 in the cycle after the reset edge. The first request after rst_f returns high is serviced with normal latency.
- Outputs are registered; there are no combinational paths from req to ack or to mem_*.

## Test plan
- Reset: rst_f low for 2 cycles with both reqs high -> all outputs 0 and busy = 0 during reset. Data is granted first after release.
- Fetch read, MEM_LAT=1: if_addr=0x0010, memory returns 0xDEADBEEF -> cycle 1 mem_en=1, mem_we=0, mem_addr=0x0010; cycle 2 if_ack=1, if_rdata=0xDEADBEEF; dm_ack stays 0.
- Tie and round-robin: if_req and dm_req both high at cycle 0 after reset -> dm_ack at cycle 2, last_grant=1; fetch granted in the next IDLE (cycle 3), if_ack at cycle 5, last_grant=0.
- Store: dm_we=1, dm_addr=0x0020, dm_wdata=0x12345678 -> cycle 1 mem_en=1, mem_we=1, mem_wdata=0x12345678; dm_ack at cycle 2; dm_rdata unchanged.
- MEM_LAT=3 load at dm_addr=0x0004, memory returns 0xCAFEF00D -> mem_en high in cycle 1 only; dm_ack at cycle 4 with dm_rdata=0xCAFEF00D. Same test with hold=1 in cycle 0: no grant until hold drops.
- Reset mid-access: rst_f low in the second WAIT cycle (MEM_LAT=3) -> no ack, all outputs 0 next cycle. A subsequent fetch to 0x0001 completes in 4 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sequencer sharing one memory port between instruction fetch and data access.
// Ports: clk/rst_f (sync, active-low), hold blocks new grants;
//   if_req/if_addr -> if_ack/if_rdata   fetch port (read only)
//   dm_req/dm_we/dm_addr/dm_wdata -> dm_ack/dm_rdata   data port
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata   memory side
//   busy (not IDLE), last_grant (0 = fetch, 1 = data)
module mem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          hold,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          last_grant
);
  if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_lat
    $error("mem_arbiter: MEM_LAT must be in 1..7");
  end
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;
  state_e        state_q, state_d;
  logic          port_q, we_q, last_grant_q;
  logic          if_ack_q, dm_ack_q, mem_en_q, mem_we_q;
  logic          if_ack_d, dm_ack_d, mem_en_d, mem_we_d;
  logic [2:0]    cnt_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, if_rdata_q, dm_rdata_q;
  logic          grant, pick_dm, done;
  assign grant   = state_q == IDLE && !hold && (if_req || dm_req);
  // on a tie the port opposite the previous winner gets the memory
  assign pick_dm = dm_req && (!if_req || !last_grant_q);
  assign done    = state_q == WAIT && cnt_q == 3'd0;
  always_ff @(posedge clk)
    if (!rst_f) state_q <= IDLE;
    else        state_q <= state_d;
  always_comb
    state_d = state_q == IDLE ? (grant ? WAIT : IDLE) :
              state_q == WAIT ? (done ? ACK : WAIT) : IDLE;
  // next values of the registered strobes: memory strobe on the grant edge, ack on the final WAIT edge
  always_comb begin
    mem_en_d = grant;
    mem_we_d = grant && pick_dm && dm_we;
    if_ack_d = done && !port_q;
    dm_ack_d = done && port_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      last_grant_q <= 1'b0;
      cnt_q        <= 3'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      if_ack_q     <= 1'b0;
      dm_ack_q     <= 1'b0;
    end else begin
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
      if_ack_q <= if_ack_d;
      dm_ack_q <= dm_ack_d;
      if (grant) begin
        port_q       <= pick_dm;
        we_q         <= pick_dm && dm_we;
        last_grant_q <= pick_dm;
        addr_q       <= pick_dm ? dm_addr : if_addr;
        wdata_q      <= dm_wdata;
        // writes finish after a single WAIT cycle regardless of read latency
        cnt_q        <= (pick_dm && dm_we) ? 3'd0 : 3'(MEM_LAT - 1);
      end else if (state_q == WAIT && !done) begin
        cnt_q <= cnt_q - 3'd1;
      end
      if (done && !we_q && !port_q) if_rdata_q <= mem_rdata;
      if (done && !we_q && port_q)  dm_rdata_q <= mem_rdata;
    end
  end
  assign if_ack     = if_ack_q;
  assign dm_ack     = dm_ack_q;
  assign if_rdata   = if_rdata_q;
  assign dm_rdata   = dm_rdata_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = state_q != IDLE;
  assign last_grant = last_grant_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter at MEM_LAT 1 and 3.
module tb_mem_arbiter;
  typedef struct {
    int          cyc;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wd;
  } mem_t;
  typedef struct {
    int          cyc;
    logic [31:0] rd;
  } ack_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0;
  int errors = 0;
  bit done [2];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int LAT = (g == 0) ? 1 : 3;
    logic        rst_f, hold, if_req, dm_req, dm_we;
    logic [15:0] if_addr, dm_addr, mem_addr;
    logic [31:0] dm_wdata, mem_rdata, mem_wdata, if_rdata, dm_rdata;
    logic        if_ack, dm_ack, mem_en, mem_we, busy, last_grant;
    mem_arbiter #(.AW(16), .DW(32), .MEM_LAT(LAT)) dut (
      .clk(clk), .rst_f(rst_f), .hold(hold),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .last_grant(last_grant)
    );
    logic [31:0] ram [256];
    logic [31:0] ref_mem [256];
    mem_t        mq [$];
    ack_t        iq [$];
    ack_t        dq [$];
    logic        m_lg;
    logic [31:0] m_if_rd, m_dm_rd;
    task automatic c(input string n, input logic [63:0] a, input logic [63:0] e);
      chk($sformatf("lat%0d_%s", LAT, n), a, e);
    endtask
    // memory device: read data is valid only in the cycle LAT-1 after the strobe, junk otherwise
    int          k = 99;
    logic [15:0] la;
    logic        lwe = 1'b1;
    always @(negedge clk) begin
      if (mem_en) begin
        k   = 0;
        la  = mem_addr;
        lwe = mem_we;
        if (mem_we) ram[mem_addr[7:0]] = mem_wdata;
      end else if (k < 99) begin
        k++;
      end
      mem_rdata = (k == LAT - 1 && !lwe) ? ram[la[7:0]] : $urandom();
    end
    always @(negedge clk) begin : mon
      mem_t me;
      ack_t ae;
      if (mem_en) begin
        if (mq.size() == 0) c("spurious_mem_en", 64'(mem_en), 0);
        else begin
          me = mq.pop_front();
          c("mem_en_cycle", cyc, me.cyc);
          c("mem_we", 64'(mem_we), 64'(me.we));
          c("mem_addr", 64'(mem_addr), 64'(me.addr));
          if (me.we) c("mem_wdata", 64'(mem_wdata), 64'(me.wd));
        end
      end
      if (if_ack) begin
        if (iq.size() == 0) c("spurious_if_ack", 64'(if_ack), 0);
        else begin
          ae = iq.pop_front();
          c("if_ack_cycle", cyc, ae.cyc);
          c("if_rdata", 64'(if_rdata), 64'(ae.rd));
          c("if_last_grant", 64'(last_grant), 0);
          c("if_busy", 64'(busy), 1);
        end
      end
      if (dm_ack) begin
        if (dq.size() == 0) c("spurious_dm_ack", 64'(dm_ack), 0);
        else begin
          ae = dq.pop_front();
          c("dm_ack_cycle", cyc, ae.cyc);
          c("dm_rdata", 64'(dm_rdata), 64'(ae.rd));
          c("dm_last_grant", 64'(last_grant), 1);
          c("dm_busy", 64'(busy), 1);
        end
      end
    end
    // reference: service port p granted in cycle gc, returns its ack cycle
    function automatic int svc(input bit p, input int gc);
      logic        w  = p && dm_we;
      logic [15:0] a  = p ? dm_addr : if_addr;
      int          ac = gc + 1 + (w ? 1 : LAT);
      mq.push_back('{gc + 1, w, a, dm_wdata});
      if (!p) begin
        m_if_rd = ref_mem[a[7:0]];
        iq.push_back('{ac, m_if_rd});
      end else begin
        if (w) ref_mem[a[7:0]] = dm_wdata;
        else   m_dm_rd = ref_mem[a[7:0]];
        dq.push_back('{ac, m_dm_rd});
      end
      m_lg = p;
      return ac;
    endfunction
    task automatic wait_if(input int gc);
      int n = 0;
      do begin
        @(negedge clk);
        n++;
        if (cyc > gc) if_addr = 16'($urandom());
      end while (!if_ack && n < 64);
      if (!if_ack) c("if_ack_timeout", 64'(if_ack), 1);
      if_req = 1'b0;
    endtask
    task automatic wait_dm(input int gc);
      int n = 0;
      do begin
        @(negedge clk);
        n++;
        if (cyc > gc) begin
          dm_addr  = 16'($urandom());
          dm_wdata = $urandom();
          dm_we    = 1'($urandom());
        end
      end while (!dm_ack && n < 64);
      if (!dm_ack) c("dm_ack_timeout", 64'(dm_ack), 1);
      dm_req = 1'b0;
    endtask
    // called on an IDLE-cycle negedge; returns on the next IDLE-cycle negedge
    task automatic round(input bit [1:0] mode, input int h, input logic [15:0] ia, input logic [15:0] da,
                         input logic we, input logic [31:0] wd);
      int c0 = cyc;
      int gi = 0;
      int gd = 0;
      int a1;
      if_addr = ia; dm_addr = da; dm_we = we; dm_wdata = wd;
      if_req = mode[0]; dm_req = mode[1]; hold = (h > 0);
      if (mode == 2'd3) begin
        if (!m_lg) begin
          gd = c0 + h; a1 = svc(1'b1, gd);
          gi = a1 + 1; void'(svc(1'b0, gi));
        end else begin
          gi = c0 + h; a1 = svc(1'b0, gi);
          gd = a1 + 1; void'(svc(1'b1, gd));
        end
      end else begin
        gi = c0 + h; gd = c0 + h;
        void'(svc(mode[1], c0 + h));
      end
      repeat (h) @(negedge clk);
      hold = 1'b0;
      fork
        begin if (mode[0]) wait_if(gi); end
        begin if (mode[1]) wait_dm(gd); end
      join
      @(negedge clk);
    endtask
    task automatic zero_check(input string n);
      c({n, "_ctl"}, 64'({if_ack, dm_ack, mem_en, mem_we, busy, last_grant}), 0);
      c({n, "_mem_addr"}, 64'(mem_addr), 0);
      c({n, "_mem_wdata"}, 64'(mem_wdata), 0);
      c({n, "_if_rdata"}, 64'(if_rdata), 0);
      c({n, "_dm_rdata"}, 64'(dm_rdata), 0);
    endtask
    task automatic mid_reset();
      int c0 = cyc;
      int rc = (LAT > 1) ? 2 : 1;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'($urandom()); hold = 1'b0;
      mq.push_back('{c0 + 1, 1'b0, dm_addr, dm_wdata});
      repeat (rc) @(negedge clk);
      rst_f = 1'b0; dm_req = 1'b0;
      @(negedge clk);
      zero_check("midrst");
      rst_f = 1'b1;
      m_lg = 1'b0; m_if_rd = '0; m_dm_rd = '0;
    endtask
    initial begin
      for (int i = 0; i < 256; i++) begin
        ram[i]     = $urandom();
        ref_mem[i] = ram[i];
      end
      ram[8'h10] = 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;
      ram[8'h04] = 32'hCAFEF00D; ref_mem[8'h04] = 32'hCAFEF00D;
      m_lg = 1'b0; m_if_rd = '0; m_dm_rd = '0;
      rst_f = 1'b0; hold = 1'b0; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0;
      repeat (2) begin
        @(negedge clk);
        zero_check("rst");
      end
      rst_f = 1'b1;
      round(2'd3, 0, 16'h0100, 16'h0008, 1'b0, 32'h0);
      round(2'd1, 0, 16'h0010, 16'h0000, 1'b0, 32'h0);
      round(2'd2, 0, 16'h0000, 16'h0020, 1'b1, 32'h12345678);
      round(2'd2, 0, 16'h0000, 16'h0004, 1'b0, 32'h0);
      round(2'd2, 2, 16'h0000, 16'h0004, 1'b0, 32'h0);
      round(2'd3, 0, 16'h0010, 16'h0020, 1'b0, 32'h0);
      round(2'd3, 1, 16'h0004, 16'h0010, 1'b1, 32'h55AA55AA);
      for (int r = 0; r < 40; r++)
        round(2'($urandom_range(1, 3)), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
              16'($urandom()), 16'($urandom()), 1'($urandom()), $urandom());
      mid_reset();
      round(2'd1, 0, 16'h0001, 16'h0000, 1'b0, 32'h0);
      @(negedge clk);
      c("mq_left", 64'(mq.size()), 0);
      c("iq_left", 64'(iq.size()), 0);
      c("dq_left", 64'(dq.size()), 0);
      done[g] = 1'b1;
    end
  end
  initial begin
    fork
      wait (done[0] && done[1]);
      #1000000;
    join_any
    if (!(done[0] && done[1])) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: done %0d%0d expected 11", done[0], done[1]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
